// File: rtl/msi_vec_capture.sv
// MSI vector capture block.
// Watches the TRGT1 receive interface for single-DW memory writes aimed at the
// programmed MSI address. Each accepted write sets a per-vector pending flag,
// pulses msi_detected and pushes its 32-bit payload into a small
// first-word-fall-through capture FIFO.
module msi_vec_capture #(
   parameter int NUM_VEC    = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                core_clk,
   input  logic                core_rst_n,
   input  logic                radm_trgt1_hv,
   input  logic                radm_trgt1_dv,
   input  logic                radm_trgt1_eot,
   input  logic                radm_trgt1_tlp_abort,
   input  logic [1:0]          radm_trgt1_fmt,
   input  logic [4:0]          radm_trgt1_type,
   input  logic [9:0]          radm_trgt1_dw_len,
   input  logic [3:0]          radm_trgt1_first_be,
   input  logic [63:0]         radm_trgt1_addr,
   input  logic [63:0]         radm_trgt1_data,
   output logic [2:0]          trgt1_radm_pkt_halt,
   input  logic [63:0]         msi_addr,
   input  logic                msi_en,
   input  logic [NUM_VEC-1:0]  vec_mask,
   input  logic [NUM_VEC-1:0]  int_clear,
   output logic [NUM_VEC-1:0]  msi_pending,
   output logic                msi_int,
   output logic                msi_detected,
   input  logic                fifo_rd,
   output logic [31:0]         fifo_dout,
   output logic                fifo_empty,
   output logic                fifo_full,
   output logic [15:0]         overflow_cnt
);

   localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, CAPT, DROP} state_t;

   state_t              state;
   logic [31:0]         capt_data;
   logic                dv_seen;

   logic                match_3dw;
   logic                match_4dw;
   logic                cand;
   logic                commit_raw;
   logic                commit;
   logic [31:0]         commit_data;
   logic [VW-1:0]       vec_idx;
   logic [NUM_VEC-1:0]  set_vec;

   logic [31:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [CW-1:0]       count_nxt;
   logic                push;
   logic                pop;
   logic                halt_p;
   logic                unused_data_hi;

   // Upper payload dword never carries MSI data (single-DW writes only).
   assign unused_data_hi = ^radm_trgt1_data[63:32];

   // A header qualifies as an MSI when it is a 1-DW full-byte MWr hitting the
   // programmed address; a 3DW header can only match a 32-bit MSI address.
   assign match_3dw = (radm_trgt1_fmt == 2'b10) &&
                      (radm_trgt1_addr[31:0] == msi_addr[31:0]) &&
                      (msi_addr[63:32] == 32'h0);
   assign match_4dw = (radm_trgt1_fmt == 2'b11) && (radm_trgt1_addr == msi_addr);
   assign cand      = (radm_trgt1_type == 5'b00000) && (radm_trgt1_dw_len == 10'd1) &&
                      (radm_trgt1_first_be == 4'hF) && (match_3dw || match_4dw);

   // Decide whether the TLP ending this cycle commits, and which data it carries.
   // A new header always restarts parsing, so it takes priority over CAPT.
   always_comb begin
      commit_raw  = 1'b0;
      commit_data = radm_trgt1_data[31:0];
      if (radm_trgt1_hv) begin
         commit_raw = radm_trgt1_eot && cand && radm_trgt1_dv && !radm_trgt1_tlp_abort;
      end else if ((state == CAPT) && radm_trgt1_eot) begin
         commit_raw = !radm_trgt1_tlp_abort && (dv_seen || radm_trgt1_dv);
         if (dv_seen) begin
            commit_data = capt_data;
         end
      end
   end

   assign commit  = commit_raw && msi_en;
   assign vec_idx = (NUM_VEC == 1) ? '0 : commit_data[VW-1:0];
   assign set_vec = commit ? (NUM_VEC'(1) << vec_idx) : '0;

   // Header parser: tracks whether the in-flight TLP is being captured or ignored.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state     <= IDLE;
         capt_data <= 32'h0;
         dv_seen   <= 1'b0;
      end else if (radm_trgt1_hv) begin
         if (radm_trgt1_eot) begin
            state <= IDLE;
         end else if (cand) begin
            state     <= CAPT;
            dv_seen   <= radm_trgt1_dv;
            capt_data <= radm_trgt1_data[31:0];
         end else begin
            state <= DROP;
         end
      end else begin
         case (state)
            CAPT: begin
               if (radm_trgt1_eot) begin
                  state <= IDLE;
               end
               if (radm_trgt1_dv && !dv_seen) begin
                  dv_seen   <= 1'b1;
                  capt_data <= radm_trgt1_data[31:0];
               end
            end
            DROP: begin
               if (radm_trgt1_eot) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Pending flags and detect pulse; a same-cycle set beats a clear.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         msi_detected <= 1'b0;
         msi_pending  <= '0;
      end else begin
         msi_detected <= commit;
         msi_pending  <= (msi_pending & ~int_clear) | set_vec;
      end
   end

   assign msi_int = |(msi_pending & ~vec_mask);

   // FIFO control: a pop frees a slot for a same-cycle push when full, while a
   // pop on an empty FIFO is ignored.
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(FIFO_DEPTH));
   assign pop        = fifo_rd && !fifo_empty;
   assign push       = commit && (!fifo_full || pop);
   assign count_nxt  = count + CW'(push) - CW'(pop);
   assign fifo_dout  = fifo_empty ? 32'h0 : mem[rd_ptr];

   // Capture storage, written at the tail on every accepted push.
   always_ff @(posedge core_clk) begin
      if (push) begin
         mem[wr_ptr] <= commit_data;
      end
   end

   // Pointers, occupancy, overflow count and the registered posted halt.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_cnt <= 16'h0;
         halt_p       <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count  <= count_nxt;
         halt_p <= (count_nxt >= CW'(FIFO_DEPTH - 1));
         if (commit && !push && (overflow_cnt != 16'hFFFF)) begin
            overflow_cnt <= overflow_cnt + 16'd1;
         end
      end
   end

   assign trgt1_radm_pkt_halt = {2'b00, halt_p};

endmodule

// File: tb/tb_msi_vec_capture.sv
// Testbench for msi_vec_capture: drives TRGT1 TLPs and compares the block's
// outputs with a transaction-level model of pending flags, FIFO and counters.
module tb_msi_vec_capture;

   localparam int NUM_VEC    = 32;
   localparam int FIFO_DEPTH = 8;

   logic                core_clk;
   logic                core_rst_n;
   logic                radm_trgt1_hv;
   logic                radm_trgt1_dv;
   logic                radm_trgt1_eot;
   logic                radm_trgt1_tlp_abort;
   logic [1:0]          radm_trgt1_fmt;
   logic [4:0]          radm_trgt1_type;
   logic [9:0]          radm_trgt1_dw_len;
   logic [3:0]          radm_trgt1_first_be;
   logic [63:0]         radm_trgt1_addr;
   logic [63:0]         radm_trgt1_data;
   logic [2:0]          trgt1_radm_pkt_halt;
   logic [63:0]         msi_addr;
   logic                msi_en;
   logic [NUM_VEC-1:0]  vec_mask;
   logic [NUM_VEC-1:0]  int_clear;
   logic [NUM_VEC-1:0]  msi_pending;
   logic                msi_int;
   logic                msi_detected;
   logic                fifo_rd;
   logic [31:0]         fifo_dout;
   logic                fifo_empty;
   logic                fifo_full;
   logic [15:0]         overflow_cnt;

   int checks;
   int passes;

   logic [NUM_VEC-1:0]  m_pend;
   logic [31:0]         m_q[$];
   int unsigned         m_ovf;

   msi_vec_capture #(.NUM_VEC(NUM_VEC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .core_clk             (core_clk),
      .core_rst_n           (core_rst_n),
      .radm_trgt1_hv        (radm_trgt1_hv),
      .radm_trgt1_dv        (radm_trgt1_dv),
      .radm_trgt1_eot       (radm_trgt1_eot),
      .radm_trgt1_tlp_abort (radm_trgt1_tlp_abort),
      .radm_trgt1_fmt       (radm_trgt1_fmt),
      .radm_trgt1_type      (radm_trgt1_type),
      .radm_trgt1_dw_len    (radm_trgt1_dw_len),
      .radm_trgt1_first_be  (radm_trgt1_first_be),
      .radm_trgt1_addr      (radm_trgt1_addr),
      .radm_trgt1_data      (radm_trgt1_data),
      .trgt1_radm_pkt_halt  (trgt1_radm_pkt_halt),
      .msi_addr             (msi_addr),
      .msi_en               (msi_en),
      .vec_mask             (vec_mask),
      .int_clear            (int_clear),
      .msi_pending          (msi_pending),
      .msi_int              (msi_int),
      .msi_detected         (msi_detected),
      .fifo_rd              (fifo_rd),
      .fifo_dout            (fifo_dout),
      .fifo_empty           (fifo_empty),
      .fifo_full            (fifo_full),
      .overflow_cnt         (overflow_cnt)
   );

   // Free-running core clock.
   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   // Watchdog so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // MSI acceptance rule for a header, written straight from the address rules.
   function automatic bit is_msi(input logic [1:0] fmt, input logic [4:0] typ,
                                 input logic [9:0] len, input logic [3:0] be,
                                 input logic [63:0] addr, input logic [63:0] target);
      if (typ != 5'd0 || len != 10'd1 || be != 4'hF) return 1'b0;
      if (fmt == 2'b10) return (addr[31:0] == target[31:0]) && (target[63:32] == 32'h0);
      if (fmt == 2'b11) return addr == target;
      return 1'b0;
   endfunction

   // Model effect of the cycle in which a TLP ends (clears, pop, then push).
   task automatic model_eot(input bit accept, input logic [31:0] data,
                            input logic [NUM_VEC-1:0] clr, input bit rd);
      m_pend = m_pend & ~clr;
      if (rd && m_q.size() > 0) m_q.delete(0);
      if (accept) begin
         m_pend[data % NUM_VEC] = 1'b1;
         if (m_q.size() < FIFO_DEPTH) m_q.push_back(data);
         else if (m_ovf < 65535) m_ovf = m_ovf + 1;
      end
   endtask

   task automatic idle_inputs();
      radm_trgt1_hv = 0; radm_trgt1_dv = 0; radm_trgt1_eot = 0; radm_trgt1_tlp_abort = 0;
      int_clear = '0; fifo_rd = 0;
   endtask

   task automatic do_reset();
      core_rst_n = 0;
      idle_inputs();
      repeat (2) @(negedge core_clk);
      core_rst_n = 1;
      m_pend = '0; m_q.delete(); m_ovf = 0;
   endtask

   // Two-cycle TLP: header cycle, then data+eot cycle carrying clears/pops.
   task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                           input logic [3:0] be, input logic [63:0] addr, input logic [31:0] data,
                           input bit abrt, input logic [NUM_VEC-1:0] clr, input bit rd,
                           output bit accept);
      @(negedge core_clk);
      radm_trgt1_hv = 1; radm_trgt1_fmt = fmt; radm_trgt1_type = typ;
      radm_trgt1_dw_len = len; radm_trgt1_first_be = be; radm_trgt1_addr = addr;
      @(negedge core_clk);
      radm_trgt1_hv = 0; radm_trgt1_dv = 1; radm_trgt1_data = {$urandom(), data};
      radm_trgt1_eot = 1; radm_trgt1_tlp_abort = abrt; int_clear = clr; fifo_rd = rd;
      @(negedge core_clk);
      idle_inputs();
      accept = !abrt && msi_en && is_msi(fmt, typ, len, be, addr, msi_addr);
      model_eot(accept, data, clr, rd);
   endtask

   task automatic test_reset();
      core_rst_n = 0;
      idle_inputs();
      #3;
      checks++; if (msi_pending !== '0) $display("[TB] FAIL rst_pending: got %h want 0", msi_pending); else passes++;
      checks++; if (msi_int !== 1'b0) $display("[TB] FAIL rst_int: got %b want 0", msi_int); else passes++;
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL rst_detect: got %b want 0", msi_detected); else passes++;
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) $display("[TB] FAIL rst_flags: got e=%b f=%b want e=1 f=0", fifo_empty, fifo_full); else passes++;
      checks++; if (fifo_dout !== 32'h0) $display("[TB] FAIL rst_dout: got %h want 0", fifo_dout); else passes++;
      checks++; if (overflow_cnt !== 16'h0) $display("[TB] FAIL rst_ovf: got %0d want 0", overflow_cnt); else passes++;
      checks++; if (trgt1_radm_pkt_halt !== 3'b000) $display("[TB] FAIL rst_halt: got %b want 000", trgt1_radm_pkt_halt); else passes++;
      do_reset();
   endtask

   task automatic test_basic();
      bit acc;
      do_reset();
      msi_addr = 64'hFEE0_0000; msi_en = 1; vec_mask = '0;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h5, 0, '0, 0, acc);
      checks++; if (msi_detected !== 1'b1) $display("[TB] FAIL basic_detect: got %b want 1", msi_detected); else passes++;
      checks++; if (msi_pending !== 32'h20) $display("[TB] FAIL basic_pending: got %h want 00000020", msi_pending); else passes++;
      checks++; if (msi_int !== 1'b1) $display("[TB] FAIL basic_int: got %b want 1", msi_int); else passes++;
      checks++; if (fifo_dout !== 32'h5) $display("[TB] FAIL basic_dout: got %h want 5", fifo_dout); else passes++;
      @(negedge core_clk);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL basic_pulse: got %b want 0", msi_detected); else passes++;
   endtask

   task automatic test_mask_clear();
      bit acc;
      do_reset();
      msi_addr = 64'hFEE0_0000; msi_en = 1; vec_mask = 32'h20;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h5, 0, '0, 0, acc);
      checks++; if (msi_pending !== 32'h20) $display("[TB] FAIL mask_pending: got %h want 00000020", msi_pending); else passes++;
      checks++; if (msi_int !== 1'b0) $display("[TB] FAIL mask_int: got %b want 0", msi_int); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h5, 0, 32'h20, 0, acc);
      checks++; if (msi_pending !== 32'h20) $display("[TB] FAIL set_beats_clear: got %h want 00000020", msi_pending); else passes++;
      @(negedge core_clk); int_clear = 32'h20;
      @(negedge core_clk); int_clear = '0; m_pend = m_pend & ~32'h20;
      checks++; if (msi_pending !== m_pend) $display("[TB] FAIL clear_only: got %h want %h", msi_pending, m_pend); else passes++;
      vec_mask = '0;
   endtask

   task automatic test_random();
      bit acc, abrt, rd, exp_halt;
      logic [1:0] fmt; logic [4:0] typ; logic [9:0] len; logic [3:0] be;
      logic [63:0] addr; logic [31:0] data; logic [NUM_VEC-1:0] clr; logic [31:0] exp_dout;
      do_reset();
      vec_mask = NUM_VEC'($urandom());
      for (int i = 0; i < 40; i++) begin
         msi_addr = ($urandom_range(0, 3) == 0) ? {32'h1, $urandom()} : {32'h0, $urandom()};
         msi_en   = ($urandom_range(0, 9) != 0);
         fmt  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
         typ  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         len  = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(2, 4)) : 10'd1;
         be   = ($urandom_range(0, 7) == 0) ? 4'h7 : 4'hF;
         addr = ($urandom_range(0, 3) == 0) ? (msi_addr ^ (64'h1 << $urandom_range(0, 63))) : msi_addr;
         abrt = ($urandom_range(0, 9) == 0);
         clr  = ($urandom_range(0, 3) == 0) ? NUM_VEC'($urandom()) : '0;
         rd   = ($urandom_range(0, 2) == 0);
         data = $urandom();
         send_tlp(fmt, typ, len, be, addr, data, abrt, clr, rd, acc);
         exp_dout = (m_q.size() > 0) ? m_q[0] : 32'h0;
         exp_halt = (m_q.size() >= FIFO_DEPTH - 1);
         checks++; if (msi_detected !== acc) $display("[TB] FAIL rand_detect[%0d]: got %b want %b", i, msi_detected, acc); else passes++;
         checks++; if (msi_pending !== m_pend) $display("[TB] FAIL rand_pending[%0d]: got %h want %h", i, msi_pending, m_pend); else passes++;
         checks++; if (msi_int !== |(m_pend & ~vec_mask)) $display("[TB] FAIL rand_int[%0d]: got %b want %b", i, msi_int, |(m_pend & ~vec_mask)); else passes++;
         checks++; if (fifo_dout !== exp_dout) $display("[TB] FAIL rand_dout[%0d]: got %h want %h", i, fifo_dout, exp_dout); else passes++;
         checks++; if (fifo_empty !== (m_q.size() == 0) || fifo_full !== (m_q.size() == FIFO_DEPTH)) $display("[TB] FAIL rand_flags[%0d]: got e=%b f=%b want occupancy %0d", i, fifo_empty, fifo_full, m_q.size()); else passes++;
         checks++; if (overflow_cnt !== 16'(m_ovf)) $display("[TB] FAIL rand_ovf[%0d]: got %0d want %0d", i, overflow_cnt, m_ovf); else passes++;
         checks++; if (trgt1_radm_pkt_halt !== {2'b00, exp_halt}) $display("[TB] FAIL rand_halt[%0d]: got %b want %b", i, trgt1_radm_pkt_halt, {2'b00, exp_halt}); else passes++;
      end
   endtask

   task automatic test_overflow();
      bit acc, exp_halt;
      do_reset();
      msi_addr = 64'hFEE0_0000; msi_en = 1; vec_mask = '0;
      for (int i = 0; i < 10; i++) begin
         send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h100 + 32'(i), 0, '0, 0, acc);
         exp_halt = (m_q.size() >= FIFO_DEPTH - 1);
         checks++; if (trgt1_radm_pkt_halt !== {2'b00, exp_halt}) $display("[TB] FAIL ovf_halt[%0d]: got %b want %b", i, trgt1_radm_pkt_halt, {2'b00, exp_halt}); else passes++;
         checks++; if (msi_detected !== 1'b1) $display("[TB] FAIL ovf_detect[%0d]: got %b want 1", i, msi_detected); else passes++;
      end
      checks++; if (fifo_full !== 1'b1) $display("[TB] FAIL ovf_full: got %b want 1", fifo_full); else passes++;
      checks++; if (overflow_cnt !== 16'd2) $display("[TB] FAIL ovf_count: got %0d want 2", overflow_cnt); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h1AA, 0, '0, 1, acc);
      checks++; if (overflow_cnt !== 16'd2 || fifo_full !== 1'b1) $display("[TB] FAIL full_push_pop: got ovf=%0d full=%b want ovf=2 full=1", overflow_cnt, fifo_full); else passes++;
      checks++; if (fifo_dout !== 32'h101) $display("[TB] FAIL full_push_pop_dout: got %h want 101", fifo_dout); else passes++;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         @(negedge core_clk);
         checks++; if (fifo_dout !== m_q[0]) $display("[TB] FAIL pop_order[%0d]: got %h want %h", i, fifo_dout, m_q[0]); else passes++;
         fifo_rd = 1;
         @(negedge core_clk);
         fifo_rd = 0; m_q.delete(0);
      end
      checks++; if (fifo_empty !== 1'b1 || trgt1_radm_pkt_halt !== 3'b000) $display("[TB] FAIL drained: got e=%b halt=%b want e=1 halt=000", fifo_empty, trgt1_radm_pkt_halt); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'hABCD, 0, '0, 1, acc);
      checks++; if (fifo_empty !== 1'b0 || fifo_dout !== 32'hABCD) $display("[TB] FAIL empty_push_pop: got e=%b dout=%h want e=0 dout=0000abcd", fifo_empty, fifo_dout); else passes++;
   endtask

   task automatic test_reject();
      bit acc;
      logic [NUM_VEC-1:0] pend0;
      logic [31:0] dout0;
      pend0 = msi_pending; dout0 = fifo_dout;
      msi_addr = 64'hFEE0_0000; msi_en = 1;
      send_tlp(2'b10, 5'd0, 10'd2, 4'hF, 64'hFEE0_0000, 32'h7, 0, '0, 0, acc);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL rej_len: got %b want 0", msi_detected); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0004, 32'h7, 0, '0, 0, acc);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL rej_addr: got %b want 0", msi_detected); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h7, 1, '0, 0, acc);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL rej_abort: got %b want 0", msi_detected); else passes++;
      msi_en = 0;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'hFEE0_0000, 32'h7, 0, '0, 0, acc);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL rej_disabled: got %b want 0", msi_detected); else passes++;
      msi_en = 1;
      checks++; if (msi_pending !== pend0 || msi_pending !== m_pend) $display("[TB] FAIL rej_pending: got %h want %h", msi_pending, pend0); else passes++;
      checks++; if (fifo_dout !== dout0 || fifo_empty !== (m_q.size() == 0)) $display("[TB] FAIL rej_fifo: got %h want %h", fifo_dout, dout0); else passes++;
   endtask

   task automatic test_4dw();
      bit acc;
      do_reset();
      msi_addr = 64'h1_0000_0040; msi_en = 1;
      send_tlp(2'b11, 5'd0, 10'd1, 4'hF, 64'h1_0000_0040, 32'h23, 0, '0, 0, acc);
      checks++; if (msi_pending !== 32'h8 || msi_detected !== 1'b1) $display("[TB] FAIL 4dw_vec3: got pend=%h det=%b want pend=00000008 det=1", msi_pending, msi_detected); else passes++;
      send_tlp(2'b10, 5'd0, 10'd1, 4'hF, 64'h0000_0040, 32'h11, 0, '0, 0, acc);
      checks++; if (msi_detected !== 1'b0 || msi_pending !== 32'h8) $display("[TB] FAIL 3dw_to_64b: got det=%b pend=%h want det=0 pend=00000008", msi_detected, msi_pending); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d0, d1;
      do_reset();
      d0 = $urandom(); d1 = $urandom();
      msi_addr = 64'hFEE0_0000; msi_en = 1; vec_mask = '0;
      @(negedge core_clk);
      radm_trgt1_hv = 1; radm_trgt1_dv = 1; radm_trgt1_eot = 1; radm_trgt1_fmt = 2'b10;
      radm_trgt1_type = 5'd0; radm_trgt1_dw_len = 10'd1; radm_trgt1_first_be = 4'hF;
      radm_trgt1_addr = 64'hFEE0_0000; radm_trgt1_data = {32'h0, d0};
      @(negedge core_clk);
      model_eot(1, d0, '0, 0);
      checks++; if (msi_detected !== 1'b1 || msi_pending !== m_pend) $display("[TB] FAIL b2b_first: got det=%b pend=%h want det=1 pend=%h", msi_detected, msi_pending, m_pend); else passes++;
      radm_trgt1_data = {32'h0, d1};
      @(negedge core_clk);
      idle_inputs();
      model_eot(1, d1, '0, 0);
      checks++; if (msi_detected !== 1'b1 || msi_pending !== m_pend) $display("[TB] FAIL b2b_second: got det=%b pend=%h want det=1 pend=%h", msi_detected, msi_pending, m_pend); else passes++;
      checks++; if (fifo_dout !== d0) $display("[TB] FAIL b2b_dout: got %h want %h", fifo_dout, d0); else passes++;
      @(negedge core_clk);
      checks++; if (msi_detected !== 1'b0) $display("[TB] FAIL b2b_end: got %b want 0", msi_detected); else passes++;
   endtask

   task automatic test_reset_mid_tlp();
      @(negedge core_clk);
      radm_trgt1_hv = 1; radm_trgt1_dv = 1; radm_trgt1_fmt = 2'b10; radm_trgt1_type = 5'd0;
      radm_trgt1_dw_len = 10'd1; radm_trgt1_first_be = 4'hF; radm_trgt1_addr = 64'hFEE0_0000;
      radm_trgt1_data = 64'h9;
      @(negedge core_clk);
      radm_trgt1_hv = 0; radm_trgt1_dv = 0;
      #2 core_rst_n = 0;
      #1;
      m_pend = '0; m_q.delete(); m_ovf = 0;
      checks++; if (msi_pending !== '0 || msi_int !== 1'b0 || msi_detected !== 1'b0) $display("[TB] FAIL midrst_irq: got pend=%h int=%b det=%b want all 0", msi_pending, msi_int, msi_detected); else passes++;
      checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_dout !== 32'h0) $display("[TB] FAIL midrst_fifo: got e=%b f=%b dout=%h want e=1 f=0 dout=0", fifo_empty, fifo_full, fifo_dout); else passes++;
      checks++; if (overflow_cnt !== 16'h0 || trgt1_radm_pkt_halt !== 3'b000) $display("[TB] FAIL midrst_ctr: got ovf=%0d halt=%b want 0 000", overflow_cnt, trgt1_radm_pkt_halt); else passes++;
      @(negedge core_clk);
      core_rst_n = 1;
      @(negedge core_clk);
      radm_trgt1_dv = 1; radm_trgt1_eot = 1;
      @(negedge core_clk);
      idle_inputs();
      checks++; if (msi_detected !== 1'b0 || msi_pending !== '0 || fifo_empty !== 1'b1) $display("[TB] FAIL midrst_nocommit: got det=%b pend=%h e=%b want 0 0 1", msi_detected, msi_pending, fifo_empty); else passes++;
   endtask

   // Main sequence: run each scenario in turn, then print the summary.
   initial begin
      checks = 0; passes = 0;
      core_rst_n = 0;
      radm_trgt1_fmt = 2'b00; radm_trgt1_type = 5'd0; radm_trgt1_dw_len = 10'd0;
      radm_trgt1_first_be = 4'h0; radm_trgt1_addr = 64'h0; radm_trgt1_data = 64'h0;
      msi_addr = 64'hFEE0_0000; msi_en = 1; vec_mask = '0;
      idle_inputs();
      m_pend = '0; m_ovf = 0;
      test_reset();
      test_basic();
      test_mask_clear();
      test_random();
      test_overflow();
      test_reject();
      test_4dw();
      test_back_to_back();
      test_reset_mid_tlp();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/msi_vec_capture.md
MSI_VEC_CAPTURE -- requirements
Module: msi_vec_capture

Interface
REQ-001 Parameter NUM_VEC, default 32, number of MSI vectors tracked; legal range 1..32.
REQ-002 Parameter FIFO_DEPTH, default 8, number of entries in the MSI data capture FIFO; power of 2, 2..64.
REQ-003 core_clk  in  1  clock; all logic is on its rising edge.
REQ-004 core_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 radm_trgt1_hv / radm_trgt1_dv / radm_trgt1_eot / radm_trgt1_tlp_abort  in  1 each  TRGT1 header-valid, data-valid, end-of-TLP and abort strobes.
REQ-006 radm_trgt1_fmt  in  2; radm_trgt1_type  in  5; radm_trgt1_dw_len  in  10; radm_trgt1_first_be  in  4  header fields, valid with hv.
REQ-007 radm_trgt1_addr  in  64, valid with hv; radm_trgt1_data  in  64, valid with dv.
REQ-008 trgt1_radm_pkt_halt  out  3  posted/non-posted/completion halt to core; only bit 0 (posted) is driven, bits 2:1 are tied 0.
REQ-009 msi_addr  in  64  programmed MSI target address, quasi-static.
REQ-010 msi_en  in  1  global MSI enable.
REQ-011 vec_mask  in  NUM_VEC  per-vector mask.
REQ-012 int_clear  in  NUM_VEC  per-vector pending-clear pulses.
REQ-013 msi_pending  out  NUM_VEC  per-vector pending flags.
REQ-014 msi_int  out  1  OR of (msi_pending & ~vec_mask).
REQ-015 msi_detected  out  1  one-cycle pulse per accepted MSI.
REQ-016 fifo_rd  in  1; fifo_dout  out  32; fifo_empty  out  1; fifo_full  out  1  capture-FIFO pop port.
REQ-017 overflow_cnt  out  16  count of MSIs dropped because the FIFO was full.

Function
REQ-018 Candidate MSI conditions: type==5'b00000 (MWr), dw_len==1, first_be==4'hF, and either fmt==2'b10 with addr[31:0]==msi_addr[31:0] and msi_addr[63:32]==0, or fmt==2'b11 with addr==msi_addr.
REQ-019 Parser FSM states: IDLE, CAPT, DROP.
REQ-020 IDLE: hv with candidate -> CAPT; hv without candidate -> DROP; if eot is in the same cycle as hv, the TLP is evaluated in that cycle and the FSM stays in IDLE.
REQ-021 CAPT: latch data[31:0] on the first dv; on eot commit if tlp_abort==0 and a dv was seen, then -> IDLE.
REQ-022 DROP: on eot -> IDLE; no side effects.
REQ-023 hv in CAPT/DROP without eot: discard the in-flight TLP and re-evaluate the new header per REQ-020.
REQ-024 Commit occurs only when msi_en==1; otherwise the TLP is silently dropped.
REQ-025 On commit, msi_detected=1 the cycle after eot; back-to-back commits produce back-to-back pulses, with no edge-suppression.
REQ-026 Vector index = data[clog2(NUM_VEC)-1:0], or 0 when NUM_VEC==1; upper data bits are ignored for indexing.
REQ-027 On commit, msi_pending[vec] is set the cycle after eot; masked vectors still set pending but do not contribute to msi_int.
REQ-028 int_clear[k] clears msi_pending[k] next cycle; if a set and a clear target the same vector in the same cycle, the set wins.
REQ-029 On commit, the full 32-bit data is pushed to the FIFO when not full.
REQ-030 If the FIFO is full, the push is dropped and overflow_cnt increments, saturating at 16'hFFFF; msi_detected and pending update regardless.
REQ-031 fifo_dout is first-word-fall-through; fifo_rd while empty is ignored.
REQ-032 Simultaneous push and pop with the FIFO full: both occur and no overflow is counted.
REQ-033 Simultaneous push and pop with the FIFO empty: push occurs and fifo_dout shows the new word next cycle.
REQ-034 Pointers wrap modulo FIFO_DEPTH; the occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
REQ-035 trgt1_radm_pkt_halt[0] is registered and asserted while occupancy >= FIFO_DEPTH-1.

Reset
REQ-036 Asynchronous reset forces: FSM=IDLE; msi_pending=0; msi_int=0; msi_detected=0; FIFO empty (fifo_empty=1, fifo_full=0, fifo_dout=0); overflow_cnt=0; trgt1_radm_pkt_halt=0.
REQ-037 Reset asserted mid-TLP discards that TLP; after release the parser waits for the next hv.

Verification
REQ-038 msi_addr=0xFEE0_0000, msi_en=1; 3DW MWr to 0xFEE0_0000 with data 0x0000_0005 -> msi_detected one pulse, msi_pending[5]=1, msi_int=1, fifo_dout=0x5.
REQ-039 Same write with vec_mask[5]=1 -> msi_pending[5]=1 and msi_int=0; then int_clear[5] together with a new write to vector 5 -> msi_pending[5] stays 1.
REQ-040 FIFO_DEPTH=8, 10 MSIs with no pops -> halt[0]=1 from occupancy 7, fifo_full=1, overflow_cnt=2; 8 pops return data in order.
REQ-041 TLPs with dw_len=2, then an address mismatch, then tlp_abort=1 at eot, then msi_en=0 -> no detection, no pending, FIFO unchanged.
REQ-042 4DW MWr to msi_addr=0x1_0000_0040 with data 0x23 and NUM_VEC=32 -> vector 3 pending; a 3DW MWr to 0x0000_0040 -> ignored.
REQ-043 Two consecutive matching MSIs 1 cycle apart -> two msi_detected pulses; reset asserted mid-TLP -> all outputs reach reset values and no commit occurs.
